// File: rtl/sprite_io_bank.sv
// sprite_io_bank: memory-mapped sprite coordinate bank and PS/2 scan-code FIFO.
// The CPU reads and writes it through a combinational data path for the single-cycle core.
// Define SPRITE_IO_VSYNC_SHADOW_EN to double-buffer the sprite registers. CPU stores then land
// in a pending bank that is copied to the outputs on frame_start. Without it, stores drive the
// outputs directly.
module sprite_io_bank #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0400
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    adr,
  input  logic [31:0]                    write_data,
  input  logic                           mem_write,
  input  logic                           mem_read,
  output logic [31:0]                    read_data,
  output logic                           io_hit,
  input  logic [7:0]                     kb_code,
  input  logic                           kb_valid,
  input  logic                           frame_start,
  output logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
  output logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
  output logic [NUM_SPRITES-1:0]         sprite_en
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Address decode. Word offsets: STATUS 0x100, KBDATA 0x104, CTRL 0x108.
  logic [6:0] word;
  logic       is_sprite, is_status, is_kbdata, is_ctrl;

  assign io_hit    = (adr[31:9] == BASE_ADR[31:9]);
  assign word      = adr[8:2];
  assign is_status = (word == 7'h40);
  assign is_kbdata = (word == 7'h41);
  assign is_ctrl   = (word == 7'h42);
  assign is_sprite = ~adr[8] & ({1'b0, adr[7:2]} < 7'(NUM_SPRITES));

  logic [COORD_W-1:0] wr_x, wr_y;
  logic               wr_en;
  logic               bus_wr;

  assign bus_wr = mem_write & io_hit;
  assign wr_x   = write_data[COORD_W-1:0];
  assign wr_y   = write_data[16 +: COORD_W];
  assign wr_en  = write_data[31];

  logic [NUM_SPRITES-1:0] spr_we;

  // Per-slot store strobes.
  always_comb begin
    spr_we = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      spr_we[i] = bus_wr & is_sprite & (adr[7:2] == 6'(i));
    end
  end

  logic [COORD_W-1:0]     act_x_q [NUM_SPRITES];
  logic [COORD_W-1:0]     act_y_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] act_en_q;
  logic [COORD_W-1:0]     src_x   [NUM_SPRITES];
  logic [COORD_W-1:0]     src_y   [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] src_en;

`ifdef SPRITE_IO_VSYNC_SHADOW_EN
  logic [COORD_W-1:0]     pend_x_q [NUM_SPRITES];
  logic [COORD_W-1:0]     pend_y_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] pend_en_q;

  // Pending bank: written by CPU stores.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pend_x_q[i] <= '0;
        pend_y_q[i] <= '0;
      end
      pend_en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (spr_we[i]) begin
          pend_x_q[i]  <= wr_x;
          pend_y_q[i]  <= wr_y;
          pend_en_q[i] <= wr_en;
        end
      end
    end
  end

  // Active bank: copies the pre-store pending values at frame start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        act_x_q[i] <= '0;
        act_y_q[i] <= '0;
      end
      act_en_q <= '0;
    end else if (frame_start) begin
      act_x_q  <= pend_x_q;
      act_y_q  <= pend_y_q;
      act_en_q <= pend_en_q;
    end
  end

  assign src_x  = pend_x_q;
  assign src_y  = pend_y_q;
  assign src_en = pend_en_q;
`else
  // Single bank: stores go straight to the outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        act_x_q[i] <= '0;
        act_y_q[i] <= '0;
      end
      act_en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (spr_we[i]) begin
          act_x_q[i]  <= wr_x;
          act_y_q[i]  <= wr_y;
          act_en_q[i] <= wr_en;
        end
      end
    end
  end

  assign src_x  = act_x_q;
  assign src_y  = act_y_q;
  assign src_en = act_en_q;
`endif

  // Pack the active bank onto the flat output buses.
  always_comb begin
    sprite_x  = '0;
    sprite_y  = '0;
    sprite_en = act_en_q;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      sprite_x[i*COORD_W +: COORD_W] = act_x_q[i];
      sprite_y[i*COORD_W +: COORD_W] = act_y_q[i];
    end
  end

  // Scan-code FIFO.
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          empty, full, pop, flush, clr_ovf, push_ok, push_drop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = mem_read & io_hit & is_kbdata & ~empty;
  assign flush     = bus_wr & is_ctrl & write_data[1];
  assign clr_ovf   = bus_wr & is_ctrl & write_data[0];
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign push_ok   = kb_valid & ~flush & (~full | pop);
  assign push_drop = kb_valid & ~flush & full & ~pop;

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        if (push_ok && !pop)      count_q <= count_q + CW'(1);
        else if (!push_ok && pop) count_q <= count_q - CW'(1);
      end
      // A dropped push in the same cycle as a clear keeps the flag set.
      if (push_drop)    ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (reset && push_ok) fifo_mem[wr_ptr_q] <= kb_code;
  end

  // Combinational load data; status and data read 0 while reset is held.
  always_comb begin
    read_data = '0;
    if (io_hit) begin
      if (is_sprite) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (adr[7:2] == 6'(i)) begin
            read_data[COORD_W-1:0]   = src_x[i];
            read_data[16 +: COORD_W] = src_y[i];
            read_data[31]            = src_en[i];
          end
        end
      end else if (is_status && reset) begin
        read_data = {17'b0, 7'(count_q), 5'b0, full, ovf_q, ~empty};
      end else if (is_kbdata && reset && !empty) begin
        read_data[7:0] = fifo_mem[rd_ptr_q];
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{adr[1:0], write_data, frame_start};

endmodule
